// File: rtl/mux_scan_reg.sv
// mux_scan_reg: N-channel registered multiplexer with an internal active-channel
// register. The channel is loaded explicitly (static), stepped round-robin with a
// programmable dwell (scan), or held together with the output (freeze).
module mux_scan_reg #(
  parameter int WIDTH  = 1,
  parameter int NCH    = 4,
  parameter int SELW   = 2,
  parameter int DWELLW = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH*WIDTH-1:0]  din,
  input  logic                  in_valid,
  input  logic [SELW-1:0]       sel,
  input  logic                  sel_load,
  input  logic [1:0]            mode,
  input  logic [DWELLW-1:0]     dwell,
  output logic [WIDTH-1:0]      out,
  output logic                  out_valid,
  output logic [SELW-1:0]       out_ch,
  output logic                  sel_err
);

  // Every index the channel register can encode gets a slot; slots past NCH
  // read as zero so the mux never indexes outside the bus.
  localparam int              NSLOT   = 1 << SELW;
  localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

  typedef enum logic [1:0] {
    MODE_STATIC     = 2'b00,
    MODE_SCAN       = 2'b01,
    MODE_FREEZE     = 2'b10,
    MODE_STATIC_ALT = 2'b11
  } mode_e;

  mode_e mode_s;
  assign mode_s = mode_e'(mode);

  // Round-robin successor that wraps at the last real channel, so indices
  // >= NCH are never reached even for non-power-of-2 channel counts.
  function automatic logic [SELW-1:0] next_ch(input logic [SELW-1:0] c);
    next_ch = (c == LAST_CH) ? '0 : c + SELW'(1);
  endfunction

  logic [WIDTH-1:0] ch_data [NSLOT];

  genvar k;
  generate
    for (k = 0; k < NSLOT; k++) begin : g_slot
      if (k < NCH) begin : g_real
        assign ch_data[k] = din[k*WIDTH +: WIDTH];
      end else begin : g_pad
        assign ch_data[k] = '0;
      end
    end
  endgenerate

  logic                sel_ok;
  assign sel_ok = (sel <= LAST_CH);

  logic [SELW-1:0]     cur_ch_q,    cur_ch_d;
  logic [DWELLW-1:0]   cnt_q,       cnt_d;
  logic [WIDTH-1:0]    out_q,       out_d;
  logic                out_valid_q, out_valid_d;
  logic [SELW-1:0]     out_ch_q,    out_ch_d;
  logic                sel_err_q,   sel_err_d;

  // Next-state for the channel/dwell state and the output register.
  always_comb begin
    cur_ch_d    = cur_ch_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    out_ch_d    = out_ch_q;
    sel_err_d   = sel_load && !sel_ok;

    // Output stage samples the channel that was active before this edge;
    // freeze holds data/index and drops valid.
    if (mode_s != MODE_FREEZE) begin
      out_d       = ch_data[cur_ch_q];
      out_ch_d    = cur_ch_q;
      out_valid_d = in_valid;
    end

    // A valid explicit load wins over scan stepping in every mode and
    // restarts the dwell count; invalid loads leave the state alone.
    if (sel_load && sel_ok) begin
      cur_ch_d = sel;
      cnt_d    = '0;
    end else begin
      case (mode_s)
        MODE_SCAN: begin
          if (cnt_q == dwell) begin
            cur_ch_d = next_ch(cur_ch_q);
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + DWELLW'(1);
          end
        end
        MODE_FREEZE: begin
          cur_ch_d = cur_ch_q;
          cnt_d    = cnt_q;
        end
        default: begin
          cnt_d = '0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_ch_q    <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      cur_ch_q    <= cur_ch_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_scan_reg.sv
// Bench for mux_scan_reg: a 4-channel and a 3-channel instance share control
// inputs; a behavioural model is checked every cycle, plus directed literals.
module tb_mux_scan_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] din4;
  logic [23:0] din3;
  logic        in_valid;
  logic [1:0]  sel;
  logic        sel_load;
  logic [1:0]  mode;
  logic [3:0]  dwell;

  logic [7:0]  o4, o3;
  logic        ov4, ov3, e4, e3;
  logic [1:0]  oc4, oc3;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  assign din3 = din4[23:0];

  always #5 clk = ~clk;

  mux_scan_reg #(.WIDTH(8), .NCH(4), .SELW(2), .DWELLW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .din(din4), .in_valid(in_valid), .sel(sel),
    .sel_load(sel_load), .mode(mode), .dwell(dwell),
    .out(o4), .out_valid(ov4), .out_ch(oc4), .sel_err(e4));

  mux_scan_reg #(.WIDTH(8), .NCH(3), .SELW(2), .DWELLW(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .din(din3), .in_valid(in_valid), .sel(sel),
    .sel_load(sel_load), .mode(mode), .dwell(dwell),
    .out(o3), .out_valid(ov3), .out_ch(oc3), .sel_err(e3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_ch [2]  = '{0, 0};
  int m_cnt[2]  = '{0, 0};
  int e_out[2]  = '{0, 0};
  int e_ov [2]  = '{0, 0};
  int e_och[2]  = '{0, 0};
  int e_err[2]  = '{0, 0};

  task automatic model_step(input int i);
    int nch;
    bit good;
    nch  = (i == 0) ? 4 : 3;
    good = (int'(sel) < nch);
    e_err[i] = (sel_load && !good) ? 1 : 0;
    if (mode != 2'b10) begin
      e_out[i] = (din4 >> (8 * m_ch[i])) & 32'hFF;
      e_och[i] = m_ch[i];
      e_ov[i]  = in_valid ? 1 : 0;
    end else begin
      e_ov[i] = 0;
    end
    if (sel_load && good) begin
      m_ch[i]  = int'(sel);
      m_cnt[i] = 0;
    end else if (mode == 2'b01) begin
      if (m_cnt[i] == int'(dwell)) begin
        m_ch[i]  = (m_ch[i] + 1) % nch;
        m_cnt[i] = 0;
      end else begin
        m_cnt[i] = (m_cnt[i] + 1) % 16;
      end
    end else if (mode != 2'b10) begin
      m_cnt[i] = 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_ch[i] = 0; m_cnt[i] = 0; e_out[i] = 0; e_ov[i] = 0; e_och[i] = 0; e_err[i] = 0;
      end
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(posedge clk) begin
    #1;
    if (rst_n && chk_en) begin
      chk("m4.out",       32'(o4),  32'(e_out[0]));
      chk("m4.out_valid", 32'(ov4), 32'(e_ov[0]));
      chk("m4.out_ch",    32'(oc4), 32'(e_och[0]));
      chk("m4.sel_err",   32'(e4),  32'(e_err[0]));
      chk("m3.out",       32'(o3),  32'(e_out[1]));
      chk("m3.out_valid", 32'(ov3), 32'(e_ov[1]));
      chk("m3.out_ch",    32'(oc3), 32'(e_och[1]));
      chk("m3.sel_err",   32'(e3),  32'(e_err[1]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  int seq4_exp[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
  int seq3_exp[10] = '{0, 0, 1, 1, 2, 2, 0, 0, 1, 1};

  initial begin
    din4 = 32'h44332211; in_valid = 1'b1; sel = 2'd0; sel_load = 1'b0;
    mode = 2'b00; dwell = 4'd1;
    cyc(); cyc();
    chk("rst.out",    32'(o4),  32'h0);
    chk("rst.valid",  32'(ov4), 32'h0);
    chk("rst.out_ch", 32'(oc4), 32'h0);
    chk("rst.err",    32'(e3),  32'h0);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;

    // Static load of channel 2
    cyc();
    sel = 2'd2; sel_load = 1'b1;
    cyc();
    sel_load = 1'b0;
    cyc();
    chk("static.out",    32'(o4),  32'h33);
    chk("static.out_ch", 32'(oc4), 32'd2);
    cyc(); cyc();
    chk("static.hold", 32'(o4), 32'h33);

    // in_valid toggling; data still tracks din while invalid
    in_valid = 1'b0; din4 = 32'h44552211;
    cyc();
    chk("iv.valid0", 32'(ov4), 32'h0);
    chk("iv.data0",  32'(o4),  32'h55);
    in_valid = 1'b1; din4 = 32'h44332211;
    cyc();
    chk("iv.valid1", 32'(ov4), 32'h1);
    chk("iv.data1",  32'(o4),  32'h33);

    // Scan, dwell=1, from channel 0
    sel = 2'd0; sel_load = 1'b1;
    cyc();
    sel_load = 1'b0; mode = 2'b01; dwell = 4'd1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk($sformatf("scan4[%0d]", i), 32'(oc4), 32'(seq4_exp[i]));
      chk($sformatf("scan3[%0d]", i), 32'(oc3), 32'(seq3_exp[i]));
    end

    // Out-of-range select: only the 3-channel instance flags it
    mode = 2'b00; sel = 2'd3; sel_load = 1'b1;
    cyc();
    sel_load = 1'b0;
    chk("selerr.m3", 32'(e3), 32'h1);
    chk("selerr.m4", 32'(e4), 32'h0);
    cyc();
    chk("selerr.pulse", 32'(e3),  32'h0);
    chk("selerr.keep3", 32'(oc3), 32'd2);
    chk("selerr.load4", 32'(oc4), 32'd3);

    // Load beats advance when cnt == dwell
    sel = 2'd1; sel_load = 1'b1;
    cyc();
    sel_load = 1'b0; mode = 2'b01; dwell = 4'd1;
    cyc();
    sel = 2'd1; sel_load = 1'b1;
    cyc();
    sel_load = 1'b0;
    cyc();
    chk("prio.a", 32'(oc4), 32'd1);
    cyc();
    chk("prio.b", 32'(oc4), 32'd1);
    cyc();
    chk("prio.c", 32'(oc4), 32'd2);

    // Freeze with out = 0x22, then resume scanning
    mode = 2'b00; sel = 2'd1; sel_load = 1'b1;
    cyc();
    sel_load = 1'b0;
    cyc();
    chk("frz.pre", 32'(o4), 32'h22);
    mode = 2'b10; din4 = 32'h99887766;
    cyc();
    chk("frz.out",   32'(o4),  32'h22);
    chk("frz.valid", 32'(ov4), 32'h0);
    din4 = 32'h99887755;
    cyc();
    chk("frz.out2", 32'(o4), 32'h22);
    mode = 2'b01; dwell = 4'd0;
    cyc();
    chk("frz.res_ch", 32'(oc4), 32'd1);
    chk("frz.res_d",  32'(o4),  32'h77);
    cyc();
    chk("frz.next", 32'(oc4), 32'd2);
    chk("frz.nextd", 32'(o4), 32'h88);

    // Freeze with simultaneous load, then release in static mode
    mode = 2'b10; sel = 2'd3; sel_load = 1'b1;
    cyc();
    sel_load = 1'b0;
    chk("frzld.valid", 32'(ov4), 32'h0);
    mode = 2'b00;
    cyc();
    chk("frzld.ch",  32'(oc4), 32'd3);
    chk("frzld.out", 32'(o4),  32'h99);

    // Asynchronous reset mid-scan on channel 2
    din4 = 32'h44332211; sel = 2'd2; sel_load = 1'b1;
    cyc();
    sel_load = 1'b0; mode = 2'b01; dwell = 4'd3;
    cyc(); cyc();
    chk("pre_rst.out", 32'(o4), 32'h33);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.out",    32'(o4),  32'h0);
    chk("arst.valid",  32'(ov4), 32'h0);
    chk("arst.out_ch", 32'(oc4), 32'h0);
    chk("arst.err",    32'(e4),  32'h0);
    #3 rst_n = 1'b1;
    cyc();
    chk("post_rst.ch",  32'(oc4), 32'd0);
    chk("post_rst.out", 32'(o4),  32'h11);
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
